// File: rtl/ftm_load_rd.sv
// ftm_load_rd: pops load descriptors, issues 8x64b AXI INCR reads, streams data out.
// Ports: descriptor FIFO (pop/dout/empty), AXI AR+R master, AXI-Stream master, status.
module ftm_load_rd #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 1
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              fifo_rd_en,
  input  logic [63:0]       fifo_dout,
  input  logic              fifo_empty,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [63:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [63:0]       m_tdata,
  output logic [7:0]        m_tkeep,
  output logic [6:0]        m_tuser,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              busy,
  output logic              desc_done,
  output logic              err_resp,
  output logic              err_desc,
  input  logic              err_clr
);

  typedef enum logic [1:0] {
    IDLE, LATCH, AR, RD
  } state_t;

  state_t            state_q, state_d;
  logic              idle_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [17:0]       left_q, left_d;
  logic [6:0]        vb_q, vb_d;
  logic [6:0]        user_q, user_d;
  logic [2:0]        beat_q, beat_d;
  logic              done_q, done_d;
  logic              eresp_q, eresp_d;
  logic              edesc_q, edesc_d;

  logic       last_b;
  logic [7:0] vb8, off8, rem8;
  logic [3:0] nbytes;
  logic [8:0] keep9;
  logic       fwd;
  logic       r_hs;
  logic       burst_end;
  logic [6:0] v_in;
  logic       bad_desc;
  logic       bad_resp;

  assign m_axi_arlen   = 8'd7;
  assign m_axi_arsize  = 3'd3;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arid    = '0;

  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = (state_q == AR);
  assign m_tuser       = user_q;
  assign busy          = (state_q != IDLE);
  assign desc_done     = done_q;
  assign err_resp      = eresp_q;
  assign err_desc      = edesc_q;

  // Beat datapath: bytes remaining in the last burst decide keep/last/drop.
  always_comb begin
    last_b = (left_q == 18'd1);
    vb8    = {1'b0, vb_q};
    off8   = {2'b00, beat_q, 3'b000};
    rem8   = vb8 - off8;
    if (!last_b) begin
      nbytes = 4'd8;
    end else if (vb8 <= off8) begin
      nbytes = 4'd0;
    end else if (rem8 >= 8'd8) begin
      nbytes = 4'd8;
    end else begin
      nbytes = rem8[3:0];
    end
    keep9 = (9'd1 << nbytes) - 9'd1;
    fwd   = (state_q == RD) && (nbytes != 4'd0);

    // Empty beats are swallowed regardless of stream back-pressure.
    m_axi_rready = (state_q == RD) && (fwd ? m_tready : 1'b1);
    m_tvalid     = fwd && m_axi_rvalid;
    m_tdata      = fwd ? m_axi_rdata : 64'd0;
    m_tkeep      = fwd ? keep9[7:0] : 8'd0;
    m_tlast      = fwd && last_b && (vb8 <= off8 + 8'd8);

    r_hs      = m_axi_rready && m_axi_rvalid;
    burst_end = r_hs && (m_axi_rlast || (beat_q == 3'd7));
    bad_resp  = r_hs && ((m_axi_rresp != 2'b00) ||
                         (m_axi_rlast && (beat_q != 3'd7)));

    v_in     = fifo_dout[6:0];
    bad_desc = (state_q == LATCH) &&
               ((fifo_dout[37:32] != 6'd0) || (v_in > 7'd64));
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    left_d     = left_q;
    vb_d       = vb_q;
    user_d     = user_q;
    beat_d     = beat_q;
    done_d     = 1'b0;
    fifo_rd_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        // idle_q keeps the pop one cycle after (re)entering IDLE.
        if (idle_q && !fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = LATCH;
        end
      end
      LATCH: begin
        addr_d = {fifo_dout[63:38], 6'd0};
        left_d = fifo_dout[24:7];
        user_d = fifo_dout[31:25];
        vb_d   = ((v_in == 7'd0) || (v_in > 7'd64)) ? 7'd64 : v_in;
        if (fifo_dout[24:7] == 18'd0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = AR;
        end
      end
      AR: begin
        if (m_axi_arready) begin
          beat_d  = 3'd0;
          state_d = RD;
        end
      end
      RD: begin
        if (r_hs) begin
          beat_d = beat_q + 3'd1;
        end
        if (burst_end) begin
          if (last_b) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            left_d  = left_q - 18'd1;
            addr_d  = addr_q + ADDR_W'(64);
            state_d = AR;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new error event overrides a coincident clear.
    eresp_d = (eresp_q && !err_clr) || bad_resp;
    edesc_d = (edesc_q && !err_clr) || bad_desc;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      idle_q  <= 1'b0;
      addr_q  <= '0;
      left_q  <= '0;
      vb_q    <= '0;
      user_q  <= '0;
      beat_q  <= '0;
      done_q  <= 1'b0;
      eresp_q <= 1'b0;
      edesc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= (state_q == IDLE);
      addr_q  <= addr_d;
      left_q  <= left_d;
      vb_q    <= vb_d;
      user_q  <= user_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
      eresp_q <= eresp_d;
      edesc_q <= edesc_d;
    end
  end

endmodule

// File: tb/tb_ftm_load_rd.sv
// tb_ftm_load_rd: directed bench with FIFO, AXI slave and stream sink models.
// Expected beats come from a small descriptor-to-stream model in the bench.
module tb_ftm_load_rd;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        fifo_rd_en;
  logic [63:0] fifo_dout;
  logic        fifo_empty;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic [0:0]  m_axi_arid;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic [6:0]  m_tuser;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic        busy;
  logic        desc_done;
  logic        err_resp;
  logic        err_desc;
  logic        err_clr;

  always #5 clk = ~clk;

  ftm_load_rd #(.ADDR_W(32), .ID_W(1)) dut (
    .clk(clk), .rstn(rstn),
    .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arid(m_axi_arid), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser),
    .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .busy(busy), .desc_done(desc_done), .err_resp(err_resp),
    .err_desc(err_desc), .err_clr(err_clr)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic [6:0]  u;
    logic        l;
  } beat_t;

  beat_t       got[$];
  beat_t       exp_q[$];
  logic [63:0] desc_q[$];
  logic [31:0] ar_log[$];
  int          pop_cyc[$];
  int          done_cyc[$];

  int cyc = 0, done_cnt = 0, rhs_cnt = 0;
  int rr_viol = 0, ar_viol = 0;
  int ar_delay = 0, err_beat = -1, rlast_at = 7, tr_mode = 0;
  bit clr_req = 0, clr_with_err = 0;
  int npass = 0, ntot = 0;

  bit          in_burst = 0, ar_pend = 0;
  int          sbeat = 0, dcnt = 0;
  logic [31:0] cur_addr = 0, ar_first = 0;
  logic [3:0]  pat = 4'b1001;

  initial begin : bfm
    bit    ar_hs, r_hs, pop, arv;
    beat_t bt;
    fifo_empty = 1'b1; fifo_dout = '0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0;
    m_axi_rresp = 0; m_axi_rlast = 0; m_tready = 1; err_clr = 0;
    forever begin
      @(negedge clk);
      arv   = m_axi_arvalid;
      ar_hs = m_axi_arvalid && m_axi_arready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      pop   = fifo_rd_en;
      if (pop) pop_cyc.push_back(cyc);
      if (desc_done) begin
        done_cnt++;
        done_cyc.push_back(cyc);
      end
      if (m_tvalid && m_tready) begin
        bt.d = m_tdata; bt.k = m_tkeep; bt.u = m_tuser; bt.l = m_tlast;
        got.push_back(bt);
      end
      if (m_tvalid && (m_axi_rready !== m_tready)) rr_viol++;
      if (arv) begin
        if (ar_pend && (m_axi_araddr !== ar_first)) ar_viol++;
        if (!ar_pend) begin
          ar_pend  = 1;
          ar_first = m_axi_araddr;
        end
      end
      if (r_hs) rhs_cnt++;
      @(posedge clk);
      cyc++;
      #1;
      err_clr = 0;
      if (!rstn) begin
        in_burst = 0; ar_pend = 0; dcnt = 0;
        m_axi_arready = 0; m_axi_rvalid = 0;
        m_axi_rlast = 0; m_axi_rresp = 0;
      end else begin
        if (pop && desc_q.size() > 0) fifo_dout = desc_q.pop_front();
        if (ar_hs) begin
          ar_log.push_back(ar_first);
          ar_pend = 0; dcnt = 0; m_axi_arready = 0;
          in_burst = 1; sbeat = 0; cur_addr = ar_first;
        end else if (arv && !in_burst) begin
          if (dcnt >= ar_delay) m_axi_arready = 1;
          else dcnt++;
        end
        if (r_hs) begin
          if (m_axi_rlast) in_burst = 0;
          sbeat++;
        end
        if (in_burst) begin
          m_axi_rvalid = 1;
          m_axi_rdata  = {cur_addr, 29'd0, 3'(sbeat)};
          m_axi_rresp  = (sbeat == err_beat) ? 2'b10 : 2'b00;
          m_axi_rlast  = (sbeat == rlast_at);
        end else begin
          m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0;
        end
        err_clr = clr_req ||
                  (clr_with_err && in_burst && (m_axi_rresp != 2'b00));
        clr_req = 0;
      end
      fifo_empty = (desc_q.size() == 0);
      m_tready = (tr_mode == 0) ? 1'b1 : pat[cyc % 4];
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] o,
                     input logic [127:0] e);
    ntot++;
    assert (o === e) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [63:0] mkd(input logic [31:0] a,
      input logic [6:0] u, input int nb, input int v);
    return {a, u, 18'(nb), 7'(v)};
  endfunction

  task automatic model(input logic [31:0] a, input int nb,
                       input int v, input logic [6:0] u);
    int          vb;
    int          by;
    logic [31:0] ab;
    beat_t       bt;
    vb = ((v == 0) || (v > 64)) ? 64 : v;
    for (int b = 0; b < nb; b++) begin
      ab = {a[31:6], 6'd0} + 32'(64 * b);
      for (int k = 0; k < 8; k++) begin
        if (b != nb - 1) by = 8;
        else if (vb - 8 * k <= 0) by = 0;
        else if (vb - 8 * k >= 8) by = 8;
        else by = vb - 8 * k;
        if (by > 0) begin
          bt.d = {ab, 29'd0, 3'(k)};
          bt.k = 8'((1 << by) - 1);
          bt.u = u;
          bt.l = (b == nb - 1) && (vb <= 8 * k + 8);
          exp_q.push_back(bt);
        end
      end
    end
  endtask

  task automatic wait_done(input string tag, input int n);
    int t = 0;
    while (done_cnt < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done"}, 128'(done_cnt >= n), 128'(1));
    tick(2);
  endtask

  task automatic cmp_stream(input string tag);
    int n;
    chk({tag, "_nbeats"}, 128'(got.size()), 128'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_b%0d", tag, i), 128'(got[i]), 128'(exp_q[i]));
  endtask

  task automatic clear_logs();
    got.delete(); exp_q.delete(); ar_log.delete();
    pop_cyc.delete(); done_cyc.delete();
    rhs_cnt = 0; rr_viol = 0; ar_viol = 0;
  endtask

  task automatic clear_errs();
    clr_req = 1;
    tick(3);
  endtask

  function automatic logic [127:0] outs();
    return 128'({fifo_rd_en, m_axi_araddr, m_axi_arvalid, m_axi_rready,
                 m_tdata, m_tkeep, m_tuser, m_tlast, m_tvalid, busy,
                 desc_done, err_resp, err_desc});
  endfunction

  initial begin : main
    int base;
    // reset with a descriptor already queued
    desc_q.push_back(mkd(32'h1000_0000, 7'h15, 2, 64));
    tick(3);
    chk("reset_outs", outs(), 128'd0);
    chk("consts", 128'({m_axi_arlen, m_axi_arsize, m_axi_arburst,
                        m_axi_arid}), 128'({8'd7, 3'd3, 2'b01, 1'b0}));
    rstn = 1;
    // basic full burst
    model(32'h1000_0000, 2, 64, 7'h15);
    wait_done("A", 1);
    cmp_stream("A");
    chk("A_arcnt", 128'(ar_log.size()), 128'(2));
    chk("A_ar0", 128'(ar_log[0]), 128'(32'h1000_0000));
    chk("A_ar1", 128'(ar_log[1]), 128'(32'h1000_0040));
    chk("A_donecnt", 128'(done_cnt), 128'(1));
    chk("A_idle", 128'({busy, err_resp, err_desc}), 128'(0));
    // partial last burst
    clear_logs();
    desc_q.push_back(mkd(32'h2000_0000, 7'h03, 1, 20));
    model(32'h2000_0000, 1, 20, 7'h03);
    wait_done("B", 2);
    cmp_stream("B");
    chk("B_rhs", 128'(rhs_cnt), 128'(8));
    chk("B_arcnt", 128'(ar_log.size()), 128'(1));
    // two n_bursts=0 descriptors back-to-back
    clear_logs();
    desc_q.push_back(mkd(32'h0, 7'h01, 0, 64));
    desc_q.push_back(mkd(32'h0, 7'h02, 0, 64));
    wait_done("C", 4);
    chk("C_latency", 128'(done_cyc[0] - pop_cyc[0]), 128'(2));
    chk("C_gap", 128'(pop_cyc[1] - pop_cyc[0]), 128'(3));
    chk("C_noar", 128'(ar_log.size()), 128'(0));
    chk("C_nobeats", 128'(got.size()), 128'(0));
    // v=0 means 64
    clear_logs();
    desc_q.push_back(mkd(32'h0000_1000, 7'h07, 1, 0));
    model(32'h0000_1000, 1, 0, 7'h07);
    wait_done("D", 5);
    cmp_stream("D");
    chk("D_errdesc", 128'(err_desc), 128'(0));
    // v=100 clamps to 64 and flags
    clear_logs();
    desc_q.push_back(mkd(32'h0000_2000, 7'h01, 1, 100));
    model(32'h0000_2000, 1, 100, 7'h01);
    wait_done("E", 6);
    cmp_stream("E");
    chk("E_errdesc", 128'(err_desc), 128'(1));
    clear_errs();
    chk("E_clr", 128'(err_desc), 128'(0));
    // unaligned address
    clear_logs();
    desc_q.push_back(mkd(32'h0000_0013, 7'h02, 1, 64));
    model(32'h0000_0013, 1, 64, 7'h02);
    wait_done("F", 7);
    cmp_stream("F");
    chk("F_ar0", 128'(ar_log[0]), 128'(32'h0));
    chk("F_errdesc", 128'(err_desc), 128'(1));
    clear_errs();
    // back-pressure and slow AR
    clear_logs();
    tr_mode = 1; ar_delay = 5;
    desc_q.push_back(mkd(32'h4000_0000, 7'h2A, 2, 40));
    model(32'h4000_0000, 2, 40, 7'h2A);
    wait_done("G", 8);
    cmp_stream("G");
    chk("G_rready", 128'(rr_viol), 128'(0));
    chk("G_arstable", 128'(ar_viol), 128'(0));
    chk("G_arcnt", 128'(ar_log.size()), 128'(2));
    tr_mode = 0; ar_delay = 0;
    // bad RRESP on beat 3
    clear_logs();
    err_beat = 3;
    desc_q.push_back(mkd(32'h5000_0000, 7'h04, 1, 64));
    model(32'h5000_0000, 1, 64, 7'h04);
    wait_done("H", 9);
    cmp_stream("H");
    chk("H_errresp", 128'(err_resp), 128'(1));
    tick(5);
    chk("H_sticky", 128'(err_resp), 128'(1));
    clear_errs();
    chk("H_clr", 128'(err_resp), 128'(0));
    err_beat = -1;
    // early RLAST on beat 5
    clear_logs();
    rlast_at = 5;
    desc_q.push_back(mkd(32'h6000_0000, 7'h05, 1, 64));
    model(32'h6000_0000, 1, 64, 7'h05);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    wait_done("I", 10);
    cmp_stream("I");
    chk("I_errresp", 128'(err_resp), 128'(1));
    clear_errs();
    rlast_at = 7;
    // clear coinciding with a new error
    clear_logs();
    chk("J_pre", 128'(err_resp), 128'(0));
    clr_with_err = 1; err_beat = 2;
    desc_q.push_back(mkd(32'h7000_0000, 7'h06, 1, 64));
    wait_done("J", 11);
    chk("J_setwins", 128'(err_resp), 128'(1));
    clr_with_err = 0; err_beat = -1;
    clear_errs();
    // reset during beat 4
    clear_logs();
    desc_q.push_back(mkd(32'h3000_0008, 7'h33, 2, 64));
    begin
      int t = 0;
      while (!(in_burst && sbeat == 4) && t < 500) begin
        @(negedge clk);
        t++;
      end
    end
    chk("K_pre", 128'({err_desc, m_tvalid, m_tuser}),
        128'({1'b1, 1'b1, 7'h33}));
    rstn = 0;
    #1;
    chk("K_rst_outs", outs(), 128'd0);
    tick(3);
    rstn = 1;
    tick(2);
    clear_logs();
    base = done_cnt;
    desc_q.push_back(mkd(32'h0800_0000, 7'h05, 1, 64));
    desc_q.push_back(mkd(32'hFFFF_FFC0, 7'h09, 2, 64));
    model(32'h0800_0000, 1, 64, 7'h05);
    model(32'hFFFF_FFC0, 2, 64, 7'h09);
    wait_done("K", base + 2);
    cmp_stream("K");
    chk("K_arcnt", 128'(ar_log.size()), 128'(3));
    chk("K_ar1", 128'(ar_log[1]), 128'(32'hFFFF_FFC0));
    chk("K_wrap", 128'(ar_log[2]), 128'(32'h0000_0000));
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
